// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Request/response bundle between a CPU memory stage (master) and a
//   multi-cycle data memory (slave).
//
//   Handshake rule for both channels: a transfer happens on a rising clock
//   edge where valid and ready are both 1. The sender holds valid and its
//   payload stable until that edge. The receiver may drive ready without
//   looking at valid.
//
//   Signals
//     req_valid   master->slave  request present on req_*
//     req_ready   slave->master  slave can accept a request this cycle
//     req_write   master->slave  1 = store, 0 = load
//     req_addr    master->slave  byte address (64 bits)
//     req_wdata   master->slave  store data, low req_size bytes used
//     req_size    master->slave  transfer size in bytes (1, 2, 4 or 8)
//     resp_valid  slave->master  response present on resp_*
//     resp_ready  master->slave  master takes the response this cycle
//     resp_rdata  slave->master  load data, zero-extended
//     resp_err    slave->master  request was illegal and was not performed
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Responder side of the CPU data-memory interface. Takes one load or
//   store at a time, keeps bytes little-endian in an internal array and
//   answers LATENCY cycles after the request is accepted.
//
//   Ports
//     clk       clock, all state changes on the rising edge
//     reset     asynchronous reset, active low
//     bus       data_mem_responder_if.slave request/response bundle
//     dbgState  current FSM state (IDLE=0, WAIT=1, RESP=2)
//
//   Parameters
//     DEPTH_BYTES  storage size in bytes (power of two, >= 8)
//     LATENCY      cycles from acceptance to resp_valid (1..15)
module data_mem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus,
  output logic [1:0]            dbgState
);
  localparam int ADDR_W = $clog2(DEPTH_BYTES);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [63:0]       rdataQ;
  logic              errQ;
  logic [7:0]        mem [DEPTH_BYTES];

  logic              accept;
  logic              sizeOk;
  logic              alignOk;
  logic              inRange;
  logic              legal;
  logic [64:0]       endAddr;
  logic [ADDR_W-1:0] baseIdx;
  logic [63:0]       loadData;

  // req_ready depends on the state register only.
  assign accept  = (state == IDLE) && bus.req_valid;
  assign baseIdx = bus.req_addr[ADDR_W-1:0];

  always_comb begin
    sizeOk  = 1'b0;
    alignOk = 1'b0;
    case (bus.req_size)
      4'd1: begin sizeOk = 1'b1; alignOk = 1'b1; end
      4'd2: begin sizeOk = 1'b1; alignOk = (bus.req_addr[0] == 1'b0); end
      4'd4: begin sizeOk = 1'b1; alignOk = (bus.req_addr[1:0] == 2'd0); end
      4'd8: begin sizeOk = 1'b1; alignOk = (bus.req_addr[2:0] == 3'd0); end
      default: begin sizeOk = 1'b0; alignOk = 1'b0; end
    endcase
  end

  // One extra bit so a top-of-address-space request cannot wrap into range.
  assign endAddr = {1'b0, bus.req_addr} + 65'(bus.req_size);
  assign inRange = (endAddr <= 65'(DEPTH_BYTES));
  assign legal   = sizeOk && alignOk && inRange;

  // Little-endian assembly; bytes beyond req_size stay zero.
  always_comb begin
    loadData = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(bus.req_size)) begin
        loadData[8*i +: 8] = mem[baseIdx + ADDR_W'(i)];
      end
    end
  end

  // Storage is deliberately not reset; a store commits on its accept edge.
  always_ff @(posedge clk) begin
    if (accept && bus.req_write && legal) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(bus.req_size)) begin
          mem[baseIdx + ADDR_W'(i)] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  // WAIT is left on the edge where the counter steps from 1 to 0, so the
  // response is visible in the LATENCY-th cycle after acceptance and a new
  // request can follow every LATENCY+1 cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rdataQ <= '0;
      errQ   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            errQ   <= ~legal;
            rdataQ <= (legal && !bus.req_write) ? loadData : '0;
            if (LATENCY == 1) begin
              state <= RESP;
              cnt   <= '0;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdataQ;
  assign bus.resp_err   = errQ;
  assign dbgState       = state;
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();
  data_mem_responder_if bus1 ();
  logic [1:0] dbg;
  logic [1:0] dbg1;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbgState(dbg)
  );

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .dbgState(dbg1)
  );

  int checks   = 0;
  int failures = 0;
  logic [64:0] exp_q[$];
  logic [7:0]  model_mem [DEPTH];

  // Reference model: returns {err, rdata} and applies legal stores.
  function automatic logic [64:0] model_op(input logic w, input logic [63:0] a,
                                           input logic [63:0] d, input logic [3:0] sz);
    logic        legal;
    logic [63:0] r;
    legal = (sz == 4'd1 || sz == 4'd2 || sz == 4'd4 || sz == 4'd8) &&
            ((a % 64'(sz)) == 64'd0) && (a <= 64'(DEPTH) - 64'(sz));
    if (!legal) return {1'b1, 64'd0};
    r = '0;
    for (int i = 0; i < int'(sz); i++) begin
      if (w) model_mem[int'(a) + i] = d[8*i +: 8];
      else   r[8*i +: 8] = model_mem[int'(a) + i];
    end
    return {1'b0, r};
  endfunction

  task automatic idle_inputs;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_size = '0; bus.resp_ready = 0;
    bus1.req_valid = 0; bus1.req_write = 0; bus1.req_addr = '0;
    bus1.req_wdata = '0; bus1.req_size = '0; bus1.resp_ready = 0;
  endtask

  // One full request on the LATENCY=2 responder, with latency and data checks.
  task automatic transact(input logic w, input logic [63:0] a, input logic [63:0] d,
                          input logic [3:0] sz, input string name);
    int n;
    int lat;
    logic [64:0] exp;
    exp_q.push_back(model_op(w, a, d, sz));
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready: got req_ready=%b expected 1", name, bus.req_ready);
      void'(exp_q.pop_front());
      return;
    end
    bus.req_valid = 1; bus.req_write = w; bus.req_addr = a;
    bus.req_wdata = d; bus.req_size = sz;
    @(posedge clk);
    @(negedge clk);
    // Scramble request fields while busy; they must be ignored.
    bus.req_valid = 0;
    bus.req_addr  = {$urandom, $urandom};
    bus.req_wdata = {$urandom, $urandom};
    bus.req_size  = 4'($urandom_range(0, 15));
    bus.req_write = 1'($urandom_range(0, 1));
    lat = 1;
    while (!bus.resp_valid && lat < 40) begin @(negedge clk); lat++; end
    checks++;
    if (lat != LAT) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles expected %0d", name, lat, LAT);
    end
    exp = exp_q.pop_front();
    checks++;
    if ({bus.resp_err, bus.resp_rdata} !== exp) begin
      failures++;
      $display("FAIL %s_data: got err=%b rdata=%h expected err=%b rdata=%h",
               name, bus.resp_err, bus.resp_rdata, exp[64], exp[63:0]);
    end
    bus.resp_ready = 1;
    @(negedge clk);
    bus.resp_ready = 0;
    bus.req_write  = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 0;
    #1;
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata, dbg} !== {3'b100, 64'd0, 2'd0}) begin
      failures++;
      $display("FAIL reset_main: got ready=%b valid=%b err=%b rdata=%h state=%0d expected 1 0 0 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata, dbg);
    end
    checks++;
    if ({bus1.req_ready, bus1.resp_valid, bus1.resp_err, bus1.resp_rdata, dbg1} !== {3'b100, 64'd0, 2'd0}) begin
      failures++;
      $display("FAIL reset_lat1: got ready=%b valid=%b err=%b rdata=%h state=%0d expected 1 0 0 0 0",
               bus1.req_ready, bus1.resp_valid, bus1.resp_err, bus1.resp_rdata, dbg1);
    end
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_store_load;
    transact(1, 64'h10, 64'h1122334455667788, 4'd8, "sl_store");
    transact(0, 64'h10, 64'h0, 4'd8, "sl_load");
  endtask

  task automatic test_byte_lanes;
    transact(1, 64'h12, 64'hFFFF_FFFF_FFFF_FFAA, 4'd1, "bl_store1");
    transact(0, 64'h10, 64'h0, 4'd4, "bl_load4");
    transact(0, 64'h16, 64'h0, 4'd2, "bl_load2");
    transact(1, 64'h18, 64'h0BAD_F00D_BEEF_1234, 4'd4, "bl_store4");
    transact(0, 64'h18, 64'h0, 4'd8, "bl_load8");
  endtask

  task automatic test_errors;
    transact(0, 64'h11, 64'h0, 4'd4, "err_misalign");
    transact(1, 64'(DEPTH - 8), 64'hA1A2A3A4A5A6A7A8, 4'd8, "err_top_store");
    transact(1, 64'(DEPTH - 4), 64'hDEADDEADDEADDEAD, 4'd8, "err_overrun");
    transact(0, 64'(DEPTH - 8), 64'h0, 4'd8, "err_reload");
    transact(0, 64'h10, 64'h0, 4'd3, "err_size3");
    transact(0, 64'h10, 64'h0, 4'd0, "err_size0");
    transact(1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1, 4'd8, "err_wrap");
    transact(0, 64'(DEPTH - 1), 64'h0, 4'd1, "edge_last_byte");
  endtask

  task automatic test_backpressure;
    logic [64:0] held;
    logic [64:0] exp;
    int n;
    transact(1, 64'h40, 64'hCAFEBABE_DEADBEEF, 4'd8, "bp_store");
    exp_q.push_back(model_op(0, 64'h40, 64'h0, 4'd8));
    @(negedge clk);
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 64'h40; bus.req_size = 4'd8;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    n = 0;
    while (!bus.resp_valid && n < 40) begin @(negedge clk); n++; end
    held = {bus.resp_err, bus.resp_rdata};
    // Competing store offered while the response is stalled.
    bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 64'h40;
    bus.req_wdata = '1; bus.req_size = 4'd8;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.resp_valid !== 1'b1 || {bus.resp_err, bus.resp_rdata} !== held) begin
        failures++;
        $display("FAIL bp_stable: cycle %0d got valid=%b data=%h expected valid=1 data=%h",
                 k, bus.resp_valid, {bus.resp_err, bus.resp_rdata}, held);
      end
      checks++;
      if (bus.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_ready: cycle %0d got req_ready=%b expected 0", k, bus.req_ready);
      end
      @(negedge clk);
    end
    bus.req_valid = 0;
    bus.req_write = 0;
    exp = exp_q.pop_front();
    checks++;
    if (held !== exp) begin
      failures++;
      $display("FAIL bp_data: got %h expected %h", held, exp);
    end
    bus.resp_ready = 1;
    @(negedge clk);
    bus.resp_ready = 0;
    transact(0, 64'h40, 64'h0, 4'd8, "bp_reload");
  endtask

  task automatic test_reset_mid_wait;
    logic [64:0] dummy;
    transact(1, 64'h20, 64'h0, 4'd1, "rst_clear");
    dummy = model_op(1, 64'h20, 64'hFF, 4'd1);
    @(negedge clk);
    bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 64'h20;
    bus.req_wdata = 64'hFF; bus.req_size = 4'd1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 0;
    checks++;
    if (dbg !== 2'd1) begin
      failures++;
      $display("FAIL rst_in_wait: got state=%0d expected 1", dbg);
    end
    reset = 0;
    #1;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || dbg !== 2'd0) begin
      failures++;
      $display("FAIL rst_mid_wait: got valid=%b ready=%b state=%0d expected 0 1 0",
               bus.resp_valid, bus.req_ready, dbg);
    end
    @(negedge clk);
    reset = 1;
    transact(0, 64'h20, 64'h0, 4'd1, "rst_reload");
  endtask

  task automatic test_random;
    logic [3:0] sizes [4];
    logic [3:0] sz;
    sizes[0] = 4'd1; sizes[1] = 4'd2; sizes[2] = 4'd4; sizes[3] = 4'd8;
    for (int i = 0; i < 8; i++)
      transact(1, 64'(256 + 8*i), {$urandom, $urandom}, 4'd8, "rnd_init");
    for (int i = 0; i < 24; i++) begin
      sz = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : sizes[$urandom_range(0, 3)];
      transact(1'($urandom_range(0, 1)), 64'(256 + $urandom_range(0, 63)),
               {$urandom, $urandom}, sz, "rnd_op");
    end
  endtask

  task automatic test_latency_one;
    logic [64:0] exp;
    @(negedge clk);
    bus1.resp_ready = 1;
    bus1.req_valid = 1; bus1.req_write = 1; bus1.req_addr = 64'h30;
    bus1.req_wdata = 64'h5A5A; bus1.req_size = 4'd2;
    exp_q.push_back({1'b0, 64'h0});
    @(posedge clk);  // accept at T
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (bus1.resp_valid !== 1'b1 || {bus1.resp_err, bus1.resp_rdata} !== exp) begin
      failures++;
      $display("FAIL l1_store_resp: got valid=%b data=%h expected valid=1 data=%h",
               bus1.resp_valid, {bus1.resp_err, bus1.resp_rdata}, exp);
    end
    checks++;
    if (bus1.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL l1_busy: got req_ready=%b expected 0", bus1.req_ready);
    end
    bus1.req_write = 0;
    exp_q.push_back({1'b0, 64'h5A5A});
    @(posedge clk);  // response consumed at T+1
    @(negedge clk);
    checks++;
    if (bus1.req_ready !== 1'b1 || bus1.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL l1_idle: got ready=%b valid=%b expected 1 0", bus1.req_ready, bus1.resp_valid);
    end
    @(posedge clk);  // second accept at T+2
    @(negedge clk);
    bus1.req_valid = 0;
    exp = exp_q.pop_front();
    checks++;
    if (bus1.resp_valid !== 1'b1 || {bus1.resp_err, bus1.resp_rdata} !== exp) begin
      failures++;
      $display("FAIL l1_load_resp: got valid=%b data=%h expected valid=1 data=%h",
               bus1.resp_valid, {bus1.resp_err, bus1.resp_rdata}, exp);
    end
    @(negedge clk);
    bus1.resp_ready = 0;
    checks++;
    if (bus1.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL l1_consumed: got resp_valid=%b expected 0", bus1.resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    test_latency_one();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
